flopr_pipe: RTL and testbench

//  Parametrised N-stage pipeline register chain with per-stage valid bits, stall
//  (hold) and per-stage flush. Successor to the single 64-bit resettable flop.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage.sv | 60 ++++++
 rtl/flopr_pipe.sv | 87 ++++++++
 tb/tb_flopr_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the default data word, the bubble value and
// small elaboration helpers. The hazard and exception units import this too.
package pipe_pkg;

    // Default datapath width of the pipelined core.
    localparam int unsigned DATA_W = 64;

    // Default data word carried between pipeline stages.
    typedef logic [DATA_W-1:0] word_t;

    // Value a stage holds when it carries no instruction.
    localparam word_t BUBBLE_VAL = '0;

    // Width needed to count 0..depth set valid bits.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// One pipeline register stage: data word plus valid bit, with load enable
// and clear. Clear wins over the enable; reset wins over everything.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(BUBBLE_VAL),
    parameter bit               ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,    // synchronous, active-low
    input  logic             en,       // 1: load d/d_valid, 0: hold
    input  logic             clr,      // 1: invalidate this stage at this edge
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_stage: WIDTH must be >= 1");
    end

    // Next-state: load or hold first, then a clear overrides the valid bit
    // (and the data word when flushed stages are meant to read as bubbles).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d  = d;
            valid_d = d_valid;
        end
        if (clr) begin
            valid_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                data_d = RESET_VAL;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule : pipe_stage

// File: rtl/flopr_pipe.sv
// N-stage pipeline register chain with per-stage valid bits, global stall and
// per-stage flush. Entries move one stage per unstalled clock; a flushed
// stage becomes a bubble. All outputs come straight from registers (occupancy
// is a popcount of registered valids), so no input reaches an output
// combinationally.
//
// Valid semantics: d_valid qualifies d on every unstalled edge; d is always
// captured, and only the valid bit distinguishes a real entry from a bubble.
// There is no backpressure: stall is an external hold, not a ready signal.
module flopr_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = DATA_W,
    parameter int unsigned      DEPTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(BUBBLE_VAL),
    parameter bit               ZERO_ON_FLUSH = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,      // synchronous, active-low
    input  logic                       stall,      // 1: hold every stage
    input  logic [DEPTH-1:0]           flush,      // bit i clears stage i
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [DEPTH-1:0]           valid_vec,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("flopr_pipe: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("flopr_pipe: DEPTH must be >= 1");
    end

    // Per-stage inputs and registered outputs.
    logic [WIDTH-1:0] stage_in      [DEPTH];
    logic [DEPTH-1:0] stage_in_valid;
    logic [WIDTH-1:0] stage_data    [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic             shift_en;

    assign shift_en = ~stall;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Stage 0 is fed from the pipe input, every later stage from its
        // predecessor.
        if (i == 0) begin : g_head
            assign stage_in[i]       = d;
            assign stage_in_valid[i] = d_valid;
        end else begin : g_body
            assign stage_in[i]       = stage_data[i-1];
            assign stage_in_valid[i] = stage_valid[i-1];
        end

        pipe_stage #(
            .WIDTH         (WIDTH),
            .RESET_VAL     (RESET_VAL),
            .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (shift_en),
            .clr     (flush[i]),
            .d       (stage_in[i]),
            .d_valid (stage_in_valid[i]),
            .q       (stage_data[i]),
            .q_valid (stage_valid[i])
        );
    end

    assign q         = stage_data[DEPTH-1];
    assign q_valid   = stage_valid[DEPTH-1];
    assign valid_vec = stage_valid;

    // Popcount of the registered valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

endmodule : flopr_pipe

// File: tb/tb_flopr_pipe.sv
// Bench for flopr_pipe: a 3-deep zero-on-flush instance and a 1-deep
// keep-on-flush instance, checked every cycle against a stage-array model
// plus hand-computed expectations for the documented scenarios.
module tb_flopr_pipe;

    localparam int W  = 64;
    localparam int D  = 3;
    localparam int OW = $clog2(D+1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 3-deep instance inputs/outputs
    logic          rst_n   = 1'b0;
    logic          stall   = 1'b0;
    logic [D-1:0]  flush   = '0;
    logic [W-1:0]  d       = '0;
    logic          d_valid = 1'b0;
    logic [W-1:0]  q;
    logic          q_valid;
    logic [D-1:0]  valid_vec;
    logic [OW-1:0] occupancy;

    // 1-deep instance inputs/outputs
    logic          rst1_n   = 1'b0;
    logic          stall1   = 1'b0;
    logic [0:0]    flush1   = '0;
    logic [W-1:0]  d1       = '0;
    logic          d1_valid = 1'b0;
    logic [W-1:0]  q1;
    logic          q1_valid;
    logic [0:0]    valid_vec1;
    logic [0:0]    occupancy1;

    flopr_pipe #(
        .WIDTH(W), .DEPTH(D), .RESET_VAL('0), .ZERO_ON_FLUSH(1'b1)
    ) dut (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .d(d), .d_valid(d_valid), .q(q), .q_valid(q_valid),
        .valid_vec(valid_vec), .occupancy(occupancy)
    );

    flopr_pipe #(
        .WIDTH(W), .DEPTH(1), .RESET_VAL('0), .ZERO_ON_FLUSH(1'b0)
    ) dut1 (
        .clk(clk), .reset(rst1_n), .stall(stall1), .flush(flush1),
        .d(d1), .d_valid(d1_valid), .q(q1), .q_valid(q1_valid),
        .valid_vec(valid_vec1), .occupancy(occupancy1)
    );

    // ---------------- model ----------------
    // m_data[i]/m_valid[i] = what stage i must hold after the latest edge.
    logic [W-1:0] m_data  [D];
    logic         m_valid [D];
    logic [W-1:0] m1_data;
    logic         m1_valid;
    logic         chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one clock edge to DUTs and model. Inputs are held stable across it.
    task automatic tick();
        logic [W-1:0] nd [D];
        logic         nv [D];
        @(posedge clk);
        for (int i = 0; i < D; i++) begin
            if (!rst_n) begin
                nd[i] = '0;
                nv[i] = 1'b0;
            end else begin
                if (stall) begin
                    nd[i] = m_data[i];
                    nv[i] = m_valid[i];
                end else if (i == 0) begin
                    nd[i] = d;
                    nv[i] = d_valid;
                end else begin
                    nd[i] = m_data[i-1];
                    nv[i] = m_valid[i-1];
                end
                if (flush[i]) begin
                    nv[i] = 1'b0;
                    nd[i] = '0;
                end
            end
        end
        for (int i = 0; i < D; i++) begin
            m_data[i]  = nd[i];
            m_valid[i] = nv[i];
        end
        // Single-stage keep-on-flush model.
        if (!rst1_n) begin
            m1_data  = '0;
            m1_valid = 1'b0;
        end else begin
            if (!stall1) begin
                m1_data  = d1;
                m1_valid = d1_valid;
            end
            if (flush1[0]) m1_valid = 1'b0;
        end
        #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int occ;
            logic [D-1:0] vv;
            occ = 0;
            for (int i = 0; i < D; i++) begin
                vv[i] = m_valid[i];
                occ += int'(m_valid[i]);
            end
            check("q",          q,                  m_data[D-1]);
            check("q_valid",    W'(q_valid),        W'(m_valid[D-1]));
            check("valid_vec",  W'(valid_vec),      W'(vv));
            check("occupancy",  W'(occupancy),      W'(occ));
            check("q1",         q1,                 m1_data);
            check("q1_valid",   W'(q1_valid),       W'(m1_valid));
            check("valid_vec1", W'(valid_vec1),     W'(m1_valid));
            check("occupancy1", W'(occupancy1),     W'(m1_valid));
        end
    end

    // Directed mixed table: {stall, flush, d_valid}
    logic [4:0] mix_tab [8];

    // ---------------- driver ----------------
    initial begin
        mix_tab[0] = {1'b0, 3'b000, 1'b1};
        mix_tab[1] = {1'b0, 3'b000, 1'b0};
        mix_tab[2] = {1'b0, 3'b001, 1'b1};
        mix_tab[3] = {1'b1, 3'b010, 1'b1};
        mix_tab[4] = {1'b0, 3'b111, 1'b1};
        mix_tab[5] = {1'b0, 3'b000, 1'b1};
        mix_tab[6] = {1'b1, 3'b000, 1'b0};
        mix_tab[7] = {1'b0, 3'b100, 1'b1};

        // 1: reset held two edges with live-looking input
        rst_n = 1'b0; rst1_n = 1'b0;
        d = 64'hFF; d_valid = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("t1_q",   q,              64'h0);
        check("t1_vv",  W'(valid_vec),  64'h0);
        check("t1_occ", W'(occupancy),  64'h0);
        rst1_n = 1'b1;

        // 2: latency stream 1..9
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            d = W'(k); d_valid = 1'b1;
            tick();
            if (k == 2) check("t2_qv_early", W'(q_valid), 64'h0);
            if (k == 3) begin
                check("t2_q_first",  q,          64'h1);
                check("t2_qv_first", W'(q_valid), 64'h1);
            end
            if (k == 9) begin
                check("t2_q_last", q,             64'h7);
                check("t2_occ",    W'(occupancy), 64'h3);
            end
        end

        // 3: stall two cycles after d=5 enters stage 0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            d = W'(k); tick();
        end
        stall = 1'b1; d = 64'h6;
        for (int s = 0; s < 2; s++) begin
            tick();
            check("t3_vv_hold", W'(valid_vec), 64'h7);
            check("t3_q_hold",  q,             64'h3);
        end
        stall = 1'b0;
        d = 64'h6; tick();
        check("t3_q4", q, 64'h4);
        d = 64'h7; tick();
        check("t3_q5", q, 64'h5);

        // 4: flush stage 1 while holding {3,2,1}
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            d = W'(k); tick();
        end
        flush = 3'b010; d = 64'h4; tick();
        check("t4_vv",  W'(valid_vec), 64'h5);
        check("t4_occ", W'(occupancy), 64'h2);
        check("t4_q",   q,             64'h2);
        flush = 3'b000; d = 64'h5; tick();
        check("t4_bubble_qv", W'(q_valid), 64'h0);
        check("t4_bubble_q",  q,           64'h0);

        // 5: flush stage 2 during stall
        d = 64'h6; tick();
        check("t5_full", W'(valid_vec), 64'h7);
        stall = 1'b1; flush = 3'b100; d = 64'h77; tick();
        check("t5_q",  q,             64'h0);
        check("t5_qv", W'(q_valid),   64'h0);
        check("t5_vv", W'(valid_vec), 64'h3);
        stall = 1'b0; flush = 3'b000; d = 64'h7; tick();
        check("t5_q_after", q, 64'h5);

        // 6: keep-on-flush depth-1 instance, plus mid-stream resets under stall
        d1 = 64'h12; d1_valid = 1'b1; tick();
        check("t6_q1_load",  q1,           64'h12);
        check("t6_qv1_load", W'(q1_valid), 64'h1);
        flush1 = 1'b1; d1 = 64'hAB; tick();
        check("t6_q1_flush",  q1,           64'hAB);
        check("t6_qv1_flush", W'(q1_valid), 64'h0);
        flush1 = 1'b0; d1 = 64'hCD; tick();
        stall1 = 1'b1; rst1_n = 1'b0;
        stall = 1'b1; rst_n = 1'b0; flush = 3'b111;
        tick();
        check("t6_q1_rst",  q1,             64'h0);
        check("t6_qv1_rst", W'(q1_valid),   64'h0);
        check("t6_vv_rst",  W'(valid_vec),  64'h0);
        check("t6_q_rst",   q,              64'h0);
        stall = 1'b0; rst_n = 1'b1; flush = 3'b000;
        stall1 = 1'b0; rst1_n = 1'b1;

        // Mixed directed vectors, checked by the model every cycle.
        for (int k = 0; k < 8; k++) begin
            logic [4:0] v;
            v       = mix_tab[k];
            stall   = v[4];
            flush   = v[3:1];
            d_valid = v[0];
            d       = 64'hA5A5_0000_0000_0000 | W'(k + 16);
            stall1   = v[4];
            flush1   = v[1];
            d1       = 64'h5A5A_0000_0000_0000 | W'(k + 32);
            d1_valid = v[0];
            tick();
        end
        stall = 1'b0; flush = '0; stall1 = 1'b0; flush1 = '0;
        for (int k = 0; k < 4; k++) begin
            d = W'(k + 100); tick();
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flopr_pipe
